// File: rtl/dp_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dp_sram_pkg
// Brief    : Shared types and helpers for the dp_sram_1rw1r memory.
// Revision : 1.0 - initial release
// ============================================================================
package dp_sram_pkg;

  localparam int c_MAX_DATA_WIDTH = 1024;
  localparam int c_MAX_BE_WIDTH   = c_MAX_DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } sram_state_e;

  // Callers pass a zero-extended enable vector and truncate the result to their width.
  function automatic logic [c_MAX_DATA_WIDTH-1:0] be_to_mask(input logic [c_MAX_BE_WIDTH-1:0] be);
    logic [c_MAX_DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < c_MAX_BE_WIDTH; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dp_sram_1rw1r_if.sv
`default_nettype none
// ============================================================================
// Module   : dp_sram_1rw1r_if
// Brief    : Request/grant/rvalid bus for the read-write port A and read port B.
// Revision : 1.0 - initial release
// ============================================================================
interface dp_sram_1rw1r_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 8
);

  logic                   a_req_i;
  logic                   a_we_i;
  logic [DataWidth/8-1:0] a_be_i;
  logic [AddrWidth-1:0]   a_addr_i;
  logic [DataWidth-1:0]   a_wdata_i;
  logic                   a_gnt_o;
  logic                   a_rvalid_o;
  logic [DataWidth-1:0]   a_rdata_o;

  logic                   b_req_i;
  logic [AddrWidth-1:0]   b_addr_i;
  logic                   b_gnt_o;
  logic                   b_rvalid_o;
  logic [DataWidth-1:0]   b_rdata_o;

  modport master (
    output a_req_i, a_we_i, a_be_i, a_addr_i, a_wdata_i, b_req_i, b_addr_i,
    input  a_gnt_o, a_rvalid_o, a_rdata_o, b_gnt_o, b_rvalid_o, b_rdata_o
  );

  modport slave (
    input  a_req_i, a_we_i, a_be_i, a_addr_i, a_wdata_i, b_req_i, b_addr_i,
    output a_gnt_o, a_rvalid_o, a_rdata_o, b_gnt_o, b_rvalid_o, b_rdata_o
  );

endinterface
`default_nettype wire

// File: rtl/dp_sram_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dp_sram_rd_pipe
// Brief    : Read-return pipeline (1 or 2 stages); rdata holds between reads.
// Revision : 1.0 - initial release
// ============================================================================
module dp_sram_rd_pipe #(
  parameter int DataWidth = 32,
  parameter int OutputReg = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rd_en_i,
  input  logic [DataWidth-1:0] rd_data_i,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o
);

  logic                 r_valid1;
  logic [DataWidth-1:0] r_data1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid1 <= 1'b0;
      r_data1  <= '0;
    end else begin
      r_valid1 <= rd_en_i;
      if (rd_en_i) begin
        r_data1 <= rd_data_i;
      end
    end
  end

  generate
    if (OutputReg != 0) begin : g_out_reg
      logic                 r_valid2;
      logic [DataWidth-1:0] r_data2;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_valid2 <= 1'b0;
          r_data2  <= '0;
        end else begin
          r_valid2 <= r_valid1;
          if (r_valid1) begin
            r_data2 <= r_data1;
          end
        end
      end

      assign rvalid_o = r_valid2;
      assign rdata_o  = r_data2;
    end else begin : g_no_out_reg
      assign rvalid_o = r_valid1;
      assign rdata_o  = r_data1;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/dp_sram_1rw1r.sv
`default_nettype none
// ============================================================================
// Module   : dp_sram_1rw1r
// Brief    : Behavioural 1RW+1R SRAM with zero-init engine and write-through merge.
// Revision : 1.0 - initial release
// ============================================================================
module dp_sram_1rw1r
  import dp_sram_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int Depth     = 256,
  parameter int AddrWidth = $clog2(Depth),
  parameter int OutputReg = 0,
  parameter int InitZero  = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  dp_sram_1rw1r_if.slave   sram,
  output logic             init_done_o
);

  localparam logic [0:0]           c_ST_INIT  = INIT;
  localparam logic [0:0]           c_ST_READY = READY;
  localparam logic [AddrWidth:0]   c_DEPTH    = (AddrWidth + 1)'(Depth);
  localparam logic [AddrWidth-1:0] c_LAST     = AddrWidth'(Depth - 1);

  logic [0:0]           r_state;
  logic [AddrWidth-1:0] r_init_cnt;
  logic [DataWidth-1:0] r_mem [Depth];

  logic                 w_ready;
  logic                 w_a_in_range;
  logic                 w_b_in_range;
  logic                 w_a_wr;
  logic                 w_a_rd;
  logic [DataWidth-1:0] w_a_mask;
  logic [DataWidth-1:0] w_a_rdata_raw;
  logic [DataWidth-1:0] w_b_old;
  logic [DataWidth-1:0] w_b_rdata_raw;
  logic                 w_init_wr;
  logic                 w_we;
  logic [AddrWidth-1:0] w_waddr;
  logic [DataWidth-1:0] w_wdata;
  logic [DataWidth-1:0] w_wmask;

  assign w_ready      = (r_state == c_ST_READY);
  assign init_done_o  = w_ready;
  assign sram.a_gnt_o = sram.a_req_i & w_ready;
  assign sram.b_gnt_o = sram.b_req_i & w_ready;

  assign w_a_in_range = ({1'b0, sram.a_addr_i} < c_DEPTH);
  assign w_b_in_range = ({1'b0, sram.b_addr_i} < c_DEPTH);
  assign w_a_mask     = DataWidth'(be_to_mask(c_MAX_BE_WIDTH'(sram.a_be_i)));
  assign w_a_wr       = sram.a_gnt_o & sram.a_we_i & w_a_in_range;
  assign w_a_rd       = sram.a_gnt_o & ~sram.a_we_i;

  assign w_a_rdata_raw = w_a_in_range ? r_mem[sram.a_addr_i] : '0;
  assign w_b_old       = w_b_in_range ? r_mem[sram.b_addr_i] : '0;

  // Same-cycle A write to B's address is forwarded byte-by-byte to B.
  assign w_b_rdata_raw = (w_a_wr && (sram.a_addr_i == sram.b_addr_i))
                       ? ((w_b_old & ~w_a_mask) | (sram.a_wdata_i & w_a_mask))
                       : w_b_old;

  assign w_init_wr = ~w_ready;
  assign w_we      = w_init_wr | w_a_wr;
  assign w_waddr   = w_init_wr ? r_init_cnt : sram.a_addr_i;
  assign w_wdata   = w_init_wr ? '0 : sram.a_wdata_i;
  assign w_wmask   = w_init_wr ? '1 : w_a_mask;

  always_ff @(posedge clk_i) begin
    if (w_we) begin
      r_mem[w_waddr] <= (r_mem[w_waddr] & ~w_wmask) | (w_wdata & w_wmask);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= (InitZero != 0) ? c_ST_INIT : c_ST_READY;
      r_init_cnt <= '0;
    end else if (r_state == c_ST_INIT) begin
      if (r_init_cnt == c_LAST) begin
        r_state <= c_ST_READY;
      end else begin
        r_init_cnt <= r_init_cnt + 1'b1;
      end
    end
  end

  dp_sram_rd_pipe #(
    .DataWidth (DataWidth),
    .OutputReg (OutputReg)
  ) u_a_pipe (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .rd_en_i   (w_a_rd),
    .rd_data_i (w_a_rdata_raw),
    .rvalid_o  (sram.a_rvalid_o),
    .rdata_o   (sram.a_rdata_o)
  );

  dp_sram_rd_pipe #(
    .DataWidth (DataWidth),
    .OutputReg (OutputReg)
  ) u_b_pipe (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .rd_en_i   (sram.b_gnt_o),
    .rd_data_i (w_b_rdata_raw),
    .rvalid_o  (sram.b_rvalid_o),
    .rdata_o   (sram.b_rdata_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_dp_sram_1rw1r.sv
`default_nettype none
// ============================================================================
// Module   : tb_dp_sram_1rw1r
// Brief    : Directed bench: u0 (Depth 256, latency 1) and u1 (Depth 200, latency 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dp_sram_1rw1r;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n;
  logic rst1_n;
  logic done0;
  logic done1;

  dp_sram_1rw1r_if #(.DataWidth(32), .AddrWidth(8)) bus0 ();
  dp_sram_1rw1r_if #(.DataWidth(32), .AddrWidth(8)) bus1 ();

  dp_sram_1rw1r #(.DataWidth(32), .Depth(256), .OutputReg(0), .InitZero(1)) u0 (
    .clk_i       (clk),
    .rst_ni      (rst0_n),
    .sram        (bus0),
    .init_done_o (done0)
  );

  dp_sram_1rw1r #(.DataWidth(32), .Depth(200), .OutputReg(1), .InitZero(1)) u1 (
    .clk_i       (clk),
    .rst_ni      (rst1_n),
    .sram        (bus1),
    .init_done_o (done1)
  );

  typedef struct {
    logic        a_req;
    logic        a_we;
    logic [3:0]  a_be;
    logic [7:0]  a_addr;
    logic [31:0] a_wdata;
    logic        b_req;
    logic [7:0]  b_addr;
    logic        exp_arv;
    logic [31:0] exp_ard;
    logic        exp_brv;
    logic [31:0] exp_brd;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle0();
    bus0.a_req_i = 1'b0; bus0.a_we_i = 1'b0; bus0.a_be_i = 4'h0;
    bus0.a_addr_i = 8'h00; bus0.a_wdata_i = 32'h0;
    bus0.b_req_i = 1'b0; bus0.b_addr_i = 8'h00;
  endtask

  task automatic idle1();
    bus1.a_req_i = 1'b0; bus1.a_we_i = 1'b0; bus1.a_be_i = 4'h0;
    bus1.a_addr_i = 8'h00; bus1.a_wdata_i = 32'h0;
    bus1.b_req_i = 1'b0; bus1.b_addr_i = 8'h00;
  endtask

  // Counts posedges after release until done0 rises; flags any gnt/rvalid on u0 before that.
  task automatic wait_init0(output int cycles, output int noise);
    cycles = 0;
    noise  = 0;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (done0) begin
        cycles = n;
        break;
      end
      if (bus0.a_gnt_o || bus0.b_gnt_o || bus0.a_rvalid_o || bus0.b_rvalid_o) noise++;
    end
  endtask

  vec_t        vecs [12];
  int          t0, t1, noise0, noise1;
  logic [31:0] exp_d [6];
  logic        exp_v [6];

  initial begin
    // a_req a_we be addr wdata b_req b_addr | arv ard brv brd
    vecs[0]  = '{1'b0, 1'b0, 4'h0, 8'h00, 32'h00000000, 1'b1, 8'hFF, 1'b0, 32'h00000000, 1'b1, 32'h00000000};
    vecs[1]  = '{1'b1, 1'b1, 4'hF, 8'h05, 32'hDEADBEEF, 1'b0, 8'h00, 1'b0, 32'h00000000, 1'b0, 32'h00000000};
    vecs[2]  = '{1'b1, 1'b1, 4'h5, 8'h05, 32'h11223344, 1'b0, 8'h00, 1'b0, 32'h00000000, 1'b0, 32'h00000000};
    vecs[3]  = '{1'b1, 1'b0, 4'h0, 8'h05, 32'h00000000, 1'b1, 8'h05, 1'b1, 32'hDE22BE44, 1'b1, 32'hDE22BE44};
    vecs[4]  = '{1'b1, 1'b1, 4'hF, 8'h09, 32'h12345678, 1'b0, 8'h00, 1'b0, 32'hDE22BE44, 1'b0, 32'hDE22BE44};
    vecs[5]  = '{1'b1, 1'b1, 4'h3, 8'h09, 32'hAABBCCDD, 1'b1, 8'h09, 1'b0, 32'hDE22BE44, 1'b1, 32'h1234CCDD};
    vecs[6]  = '{1'b1, 1'b0, 4'h0, 8'h09, 32'h00000000, 1'b1, 8'h09, 1'b1, 32'h1234CCDD, 1'b1, 32'h1234CCDD};
    vecs[7]  = '{1'b1, 1'b1, 4'h0, 8'h09, 32'hFFFFFFFF, 1'b1, 8'h09, 1'b0, 32'h1234CCDD, 1'b1, 32'h1234CCDD};
    vecs[8]  = '{1'b1, 1'b0, 4'h0, 8'h09, 32'h00000000, 1'b1, 8'h00, 1'b1, 32'h1234CCDD, 1'b1, 32'h00000000};
    vecs[9]  = '{1'b1, 1'b1, 4'h8, 8'h00, 32'h5A000000, 1'b1, 8'h00, 1'b0, 32'h1234CCDD, 1'b1, 32'h5A000000};
    vecs[10] = '{1'b1, 1'b0, 4'h0, 8'h00, 32'h00000000, 1'b1, 8'h05, 1'b1, 32'h5A000000, 1'b1, 32'hDE22BE44};
    vecs[11] = '{1'b0, 1'b0, 4'h0, 8'h00, 32'h00000000, 1'b0, 8'h00, 1'b0, 32'h5A000000, 1'b0, 32'hDE22BE44};

    idle0();
    idle1();
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    bus0.a_req_i = 1'b1; bus0.b_req_i = 1'b1;
    bus1.a_req_i = 1'b1; bus1.b_req_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_a_gnt",    {31'b0, bus0.a_gnt_o},    32'h0);
    chk("rst_b_gnt",    {31'b0, bus0.b_gnt_o},    32'h0);
    chk("rst_a_rvalid", {31'b0, bus0.a_rvalid_o}, 32'h0);
    chk("rst_b_rvalid", {31'b0, bus0.b_rvalid_o}, 32'h0);
    chk("rst_a_rdata",  bus0.a_rdata_o,           32'h0);
    chk("rst_b_rdata",  bus0.b_rdata_o,           32'h0);
    chk("rst_done0",    {31'b0, done0},           32'h0);
    chk("rst_done1",    {31'b0, done1},           32'h0);

    @(negedge clk);
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    t1 = 0;
    noise0 = 0;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (done1 && t1 == 0) t1 = n;
      if (done0) begin
        t0 = n;
        break;
      end
      if (bus0.a_gnt_o || bus0.b_gnt_o || bus0.a_rvalid_o || bus0.b_rvalid_o) noise0++;
    end
    chk("init0_cycles", t0, 256);
    chk("init1_cycles", t1, 200);
    chk("init0_quiet",  noise0, 0);

    @(negedge clk);
    idle0();
    idle1();

    // Table-driven single-cycle operations on u0 (latency 1).
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus0.a_req_i   = vecs[i].a_req;
      bus0.a_we_i    = vecs[i].a_we;
      bus0.a_be_i    = vecs[i].a_be;
      bus0.a_addr_i  = vecs[i].a_addr;
      bus0.a_wdata_i = vecs[i].a_wdata;
      bus0.b_req_i   = vecs[i].b_req;
      bus0.b_addr_i  = vecs[i].b_addr;
      #1;
      chk($sformatf("v%0d_a_gnt", i), {31'b0, bus0.a_gnt_o}, {31'b0, vecs[i].a_req});
      chk($sformatf("v%0d_b_gnt", i), {31'b0, bus0.b_gnt_o}, {31'b0, vecs[i].b_req});
      @(posedge clk); #1;
      chk($sformatf("v%0d_a_rvalid", i), {31'b0, bus0.a_rvalid_o}, {31'b0, vecs[i].exp_arv});
      chk($sformatf("v%0d_a_rdata", i),  bus0.a_rdata_o,           vecs[i].exp_ard);
      chk($sformatf("v%0d_b_rvalid", i), {31'b0, bus0.b_rvalid_o}, {31'b0, vecs[i].exp_brv});
      chk($sformatf("v%0d_b_rdata", i),  bus0.b_rdata_o,           vecs[i].exp_brd);
    end
    @(negedge clk);
    idle0();

    // u1: fill words 1..3, then write to out-of-range 200 and 250.
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus1.a_req_i   = 1'b1;
      bus1.a_we_i    = 1'b1;
      bus1.a_be_i    = 4'hF;
      bus1.a_addr_i  = (k <= 3) ? 8'(k) : ((k == 4) ? 8'd200 : 8'd250);
      bus1.a_wdata_i = (k <= 3) ? 32'h11111111 * 32'(k) : 32'hFFFFFFFF;
    end
    @(negedge clk);
    idle1();
    repeat (2) @(negedge clk);

    // Back-to-back reads of 1,2,3 with two-cycle latency.
    exp_v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_d = '{32'h0, 32'h0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h33333333};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        chk($sformatf("lat2_c%0d_rvalid", k), {31'b0, bus1.a_rvalid_o}, {31'b0, exp_v[k]});
        if (k >= 2) chk($sformatf("lat2_c%0d_rdata", k), bus1.a_rdata_o, exp_d[k]);
      end
      if (k < 3) begin
        bus1.a_req_i  = 1'b1;
        bus1.a_we_i   = 1'b0;
        bus1.a_addr_i = 8'(k + 1);
      end else begin
        idle1();
      end
    end

    // Out-of-range read returns zero with normal timing.
    @(negedge clk);
    bus1.a_req_i  = 1'b1;
    bus1.a_we_i   = 1'b0;
    bus1.a_addr_i = 8'd250;
    @(negedge clk);
    idle1();
    chk("oor_rd_early", {31'b0, bus1.a_rvalid_o}, 32'h0);
    @(negedge clk);
    chk("oor_rd_rvalid", {31'b0, bus1.a_rvalid_o}, 32'h1);
    chk("oor_rd_rdata",  bus1.a_rdata_o,           32'h0);

    // Sweep all 200 words through B: only 1..3 were written.
    for (int k = 0; k < 202; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        chk($sformatf("sweep_%0d_rvalid", k - 2), {31'b0, bus1.b_rvalid_o}, 32'h1);
        chk($sformatf("sweep_%0d_rdata", k - 2), bus1.b_rdata_o,
            (k - 2 >= 1 && k - 2 <= 3) ? 32'h11111111 * 32'(k - 2) : 32'h0);
      end
      if (k < 200) begin
        bus1.b_req_i  = 1'b1;
        bus1.b_addr_i = 8'(k);
      end else begin
        bus1.b_req_i = 1'b0;
      end
    end

    // u0: reset clears rdata; a second reset at counter 100 restarts INIT.
    @(negedge clk);
    rst0_n = 1'b0;
    #1;
    chk("rst2_a_rdata", bus0.a_rdata_o, 32'h0);
    chk("rst2_b_rdata", bus0.b_rdata_o, 32'h0);
    @(negedge clk);
    rst0_n = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst0_n = 1'b0;
    bus0.a_req_i = 1'b1; bus0.a_we_i = 1'b0; bus0.a_addr_i = 8'h05;
    bus0.b_req_i = 1'b1; bus0.b_addr_i = 8'h09;
    @(negedge clk);
    rst0_n = 1'b1;
    wait_init0(t0, noise1);
    chk("reinit_cycles", t0, 256);
    chk("reinit_quiet",  noise1, 0);
    @(posedge clk); #1;
    chk("reinit_a_rvalid", {31'b0, bus0.a_rvalid_o}, 32'h1);
    chk("reinit_a_rdata",  bus0.a_rdata_o,           32'h0);
    chk("reinit_b_rvalid", {31'b0, bus0.b_rvalid_o}, 32'h1);
    chk("reinit_b_rdata",  bus0.b_rdata_o,           32'h0);
    @(negedge clk);
    idle0();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dp_sram_1rw1r.md
# dp_sram_1rw1r

Parametrised behavioural dual-port SRAM for SoC instruction/data memories: one read/write port (A) and one read-only port (B) on a single clock. It adds req/gnt/rvalid handshakes, byte-enable writes of any data width, and a selectable one- or two-cycle read latency. A reset-time zero-initialisation engine clears the array, and same-address write/read collisions return deterministic write-through data. It replaces fixed-geometry macro models wherever RTL simulation or FPGA builds need a configurable memory.

## Interface
- DataWidth, 32, word width in bits; multiple of 8
- Depth, 256, number of words; need not be a power of two
- AddrWidth, $clog2(Depth), derived; do not override
- OutputReg, 0, 0 gives read latency 1; 1 adds an output register stage, giving latency 2
- InitZero, 1, 1 zero-fills the array after reset; 0 leaves contents X and is ready immediately

- clk_i  in  1  clock; all state changes on rising edge
- rst_ni  in  1  asynchronous active-low reset
- a_req_i  in  1  port A request
- a_we_i  in  1  1 = write, 0 = read
- a_be_i  in  DataWidth/8  byte enables; bit i covers bits [8i+7:8i]
- a_addr_i  in  AddrWidth  word address
- a_wdata_i  in  DataWidth  write data
- a_gnt_o  out  1  request accepted this cycle
- a_rvalid_o  out  1  a_rdata_o valid; pulses for reads only
- a_rdata_o  out  DataWidth  read data
- b_req_i  in  1  port B read request
- b_addr_i  in  AddrWidth  word address
- b_gnt_o  out  1  request accepted this cycle
- b_rvalid_o  out  1  b_rdata_o valid
- b_rdata_o  out  DataWidth  read data
- init_done_o  out  1  high once the array is usable

## Operation
- FSM states:
  - INIT: a counter writes zero to words 0..Depth-1, one per cycle; at Depth-1 → READY.
  - READY: normal operation; terminal until reset.
  - Reset enters INIT when InitZero=1, otherwise READY directly.
- Grants are combinational:
  - a_gnt_o = a_req_i & READY; b_gnt_o = b_req_i & READY.
  - In INIT, requests are ignored with no gnt and no rvalid; requesters must hold req.
- Port A write: bytes with a_be_i[i]=1 are updated; other bytes are unchanged. a_be_i=0 is a legal no-op with gnt. No rvalid is produced.
- Port A read / port B read: return the full word.
- Collision (A write and B read, same address, same cycle): b_rdata_o = (old & ~mask) | (a_wdata_i & mask), where mask is a_be_i expanded to bits (write-through, byte-merged).
- A read and B read at the same address: both return identical data.
- Out-of-range address (addr >= Depth):
  - writes are dropped, still granted;
  - reads return all zeros with normal rvalid timing.
- rdata holds the last read value until the next read completes; it is not cleared by writes or idle cycles.

## Timing
- Reset values: a_gnt_o/b_gnt_o 0, a_rvalid_o/b_rvalid_o 0, a_rdata_o/b_rdata_o 0, init_done_o 0 if InitZero=1 (else 1), init counter 0.
- init_done_o rises the cycle after the write to word Depth-1, i.e. Depth cycles after reset release.
- Read latency is measured from the granted edge:
  - OutputReg=0: rvalid/rdata on the next cycle (1).
  - OutputReg=1: 2 cycles.
  - Back-to-back reads give one rvalid per cycle, with no bubbles.
- Write data is visible to a read granted on the cycle after the write.
- Reset asserted mid-INIT or mid-read:
  - the pipeline flushes and rvalids are lost;
  - INIT restarts from word 0.

## Structure
- Package dp_sram_pkg holds:
  - state enum sram_state_e {INIT, READY};
  - function be_to_mask(be) returning the bit mask.
- Sub-module dp_sram_rd_pipe (parameters DataWidth, OutputReg) is instantiated once per port. It turns the granted-read strobe plus raw array data into rvalid/rdata with the hold behaviour above.
- Top level contains the array, init FSM/counter, write logic and collision merge.

## Test plan
- Reset release, InitZero=1, Depth=256: init_done_o rises at cycle 256; a B read of 0xFF then returns 0x00000000 with b_rvalid_o one cycle after gnt.
- Write 0xDEADBEEF to addr 5 with be=4'b1111, then write 0x11223344 with be=4'b0101; read addr 5 → 0xDE22BE44.
- Same cycle: A writes 0xAABBCCDD with be=4'b0011 to addr 9 (old 0x12345678), B reads addr 9 → b_rdata_o 0x1234CCDD.
- OutputReg=1: three consecutive A reads of addrs 1, 2, 3 → rvalid high on cycles +2, +3, +4 with the matching data.
- Depth=200: a read of addr 250 → 0x00000000 with rvalid; a write to 250 leaves addrs 0..199 unchanged.
- rst_ni pulsed low at init counter = 100: gnt stays 0 and init_done_o 0 until a full Depth cycles after the new release.
